// File: rtl/wt_ascii_parser.sv
// ASCII front end: encodes each accepted byte to a display code and parses "AA:BB GO" time-set commands.
// Optional WT_LOWER_CASE_EN accepts 'g'/'o' as equivalents of 'G'/'O'.
module wt_ascii_parser #(
   parameter int DIGITS = 2
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [7:0]            ASCII_IN,
   input  logic                  ASCII_VALID,
   output logic                  ASCII_READY,
   output logic [3:0]            CODE,
   output logic                  CODE_VALID,
   output logic [4*DIGITS-1:0]   FIELD_A,
   output logic [4*DIGITS-1:0]   FIELD_B,
   output logic                  CMD_VALID,
   input  logic                  CMD_READY,
   output logic                  ERR
);

   localparam int FW = 4 * DIGITS;
   localparam int CW = $clog2(DIGITS + 1);

   localparam logic [1:0] S_A   = 2'd0;
   localparam logic [1:0] S_B   = 2'd1;
   localparam logic [1:0] S_G   = 2'd2;
   localparam logic [1:0] S_OUT = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [FW-1:0] field_a_q, field_a_d;
   logic [FW-1:0] field_b_q, field_b_d;
   logic [CW-1:0] cnt_a_q, cnt_a_d;
   logic [CW-1:0] cnt_b_q, cnt_b_d;
   logic [3:0]    code_q, code_d;
   logic          code_valid_q, code_valid_d;
   logic          err_q, err_d;

   logic       accept;
   logic [3:0] enc;
   logic       is_digit, is_space, is_colon, is_g, is_o;
   logic       syntax_err;

   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      enc      = 4'hA;
      is_digit = 1'b0;
      is_g     = 1'b0;
      is_o     = 1'b0;
      is_space = (ASCII_IN == 8'h20);
      is_colon = (ASCII_IN == 8'h3A);
      if (ASCII_IN >= 8'h30 && ASCII_IN <= 8'h39) begin
         enc      = ASCII_IN[3:0];
         is_digit = 1'b1;
      end else begin
         case (ASCII_IN)
            8'h47: begin enc = 4'd11; is_g = 1'b1; end
            8'h4F: begin enc = 4'd12; is_o = 1'b1; end
`ifdef WT_LOWER_CASE_EN
            8'h67: begin enc = 4'd11; is_g = 1'b1; end
            8'h6F: begin enc = 4'd12; is_o = 1'b1; end
`endif
            8'h3A: enc = 4'd13;
            8'h20: enc = 4'd14;
            default: enc = 4'hA;
         endcase
      end
   end

   assign ASCII_READY = !RST && (state_q != S_OUT);
   assign accept      = ASCII_VALID && ASCII_READY;

   always_comb begin
      state_d      = state_q;
      field_a_d    = field_a_q;
      field_b_d    = field_b_q;
      cnt_a_d      = cnt_a_q;
      cnt_b_d      = cnt_b_q;
      code_d       = code_q;
      code_valid_d = 1'b0;
      err_d        = 1'b0;
      syntax_err   = 1'b0;

      if (state_q == S_OUT) begin
         if (CMD_READY) begin
            state_d   = S_A;
            field_a_d = '0;
            field_b_d = '0;
            cnt_a_d   = '0;
            cnt_b_d   = '0;
         end
      end else if (accept) begin
         code_d       = enc;
         code_valid_d = 1'b1;
         case (state_q)
            S_A: begin
               if (is_digit) begin
                  if (cnt_a_q == CW'(DIGITS)) syntax_err = 1'b1;
                  else begin
                     field_a_d = (field_a_q << 4) | FW'(enc);
                     cnt_a_d   = cnt_a_q + CW'(1);
                  end
               end else if (is_colon) state_d = S_B;
               else if (is_g)         state_d = S_G;
               else if (!is_space)    syntax_err = 1'b1;
            end
            S_B: begin
               if (is_digit) begin
                  if (cnt_b_q == CW'(DIGITS)) syntax_err = 1'b1;
                  else begin
                     field_b_d = (field_b_q << 4) | FW'(enc);
                     cnt_b_d   = cnt_b_q + CW'(1);
                  end
               end else if (is_g)  state_d = S_G;
               else if (!is_space) syntax_err = 1'b1;
            end
            S_G: begin
               if (is_o) state_d = S_OUT;
               else      syntax_err = 1'b1;
            end
            default: ;
         endcase
         // A syntax error discards the partial command and restarts field A.
         if (syntax_err) begin
            err_d     = 1'b1;
            state_d   = S_A;
            field_a_d = '0;
            field_b_d = '0;
            cnt_a_d   = '0;
            cnt_b_d   = '0;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= S_A;
         field_a_q    <= '0;
         field_b_q    <= '0;
         cnt_a_q      <= '0;
         cnt_b_q      <= '0;
         code_q       <= 4'hA;
         code_valid_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         field_a_q    <= field_a_d;
         field_b_q    <= field_b_d;
         cnt_a_q      <= cnt_a_d;
         cnt_b_q      <= cnt_b_d;
         code_q       <= code_d;
         code_valid_q <= code_valid_d;
         err_q        <= err_d;
      end
   end

   assign CODE       = code_q;
   assign CODE_VALID = code_valid_q;
   assign FIELD_A    = field_a_q;
   assign FIELD_B    = field_b_q;
   assign CMD_VALID  = (state_q == S_OUT);
   assign ERR        = err_q;

endmodule

// File: doc/wt_ascii_parser.md
Name: wt_ascii_parser

Overview:
- Reverse of the display path's BCD-to-ASCII conversion: accepts an ASCII byte stream (keypad/UART front end) and encodes each byte back to the 4-bit display code.
  - 0-9 → digit; 'G' → 11; 'O' → 12; ':' → 13; ' ' → 14; anything else → 10.
- Parses the stream as a time-set command of the form "AA:BB GO", accumulating two BCD fields.
- Presents the finished command to the timer control logic through a valid/ready handshake.

Parameters:
- DIGITS, 2, BCD digits per field; field width is 4*DIGITS bits.

Ports:
- CLK  input  1  clock, all state changes on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- ASCII_IN  input  8  incoming ASCII byte.
- ASCII_VALID  input  1  ASCII_IN is valid.
- ASCII_READY  output  1  the parser accepts a byte this cycle.
- CODE  output  4  display code of the last accepted byte.
- CODE_VALID  output  1  one-cycle pulse; CODE is new.
- FIELD_A  output  4*DIGITS  BCD field before ':'.
- FIELD_B  output  4*DIGITS  BCD field after ':'.
- CMD_VALID  output  1  a complete command is on FIELD_A/FIELD_B.
- CMD_READY  input  1  the consumer takes the command.
- ERR  output  1  one-cycle pulse on a syntax error.

Behaviour:
- Reset values: ASCII_READY=0 during reset and 1 after; CODE=4'hA; CODE_VALID=0; FIELD_A=0; FIELD_B=0; CMD_VALID=0; ERR=0; state S_A; both digit counters 0.
- Accept rule: a byte is accepted when ASCII_VALID && ASCII_READY.
  - ASCII_READY=1 in S_A, S_B and S_G; 0 in S_OUT.
- Latency: CODE and CODE_VALID are registered and appear the cycle after acceptance.
  - The encoding applies to every accepted byte, including bytes that cause an error.
- S_A (collect field A):
  - Digit: FIELD_A <= {FIELD_A[4*DIGITS-5:0], code}; counter A increments.
  - ' ': ignored.
  - ':': go to S_B.
  - 'G': go to S_G.
  - Anything else, or a digit when counter A==DIGITS: error.
- S_B (collect field B):
  - Digit and ' ': handled as in S_A, but on FIELD_B and counter B.
  - 'G': go to S_G.
  - ':', 'O' or an invalid byte: error.
- S_G:
  - 'O': go to S_OUT; CMD_VALID=1 on the following cycle.
  - Any other byte: error.
- S_OUT:
  - CMD_VALID held; FIELD_A and FIELD_B held stable.
  - On CMD_VALID && CMD_READY: CMD_VALID=0 next cycle, fields and counters cleared, state S_A, ASCII_READY=1 next cycle.
- Error: ERR pulses one cycle (aligned with CODE_VALID); fields and counters clear; state returns to S_A.
- Short inputs are right-aligned: "5:3 GO" gives FIELD_A=0x05, FIELD_B=0x03.
- "GO" without ':' is legal and gives FIELD_B=0.
- CMD_READY is ignored while CMD_VALID=0.
- ASCII_VALID is ignored while ASCII_READY=0; the byte is not consumed.
- Reset mid-stream aborts any partial command immediately; no CMD_VALID or ERR is generated.

Optional Feature:
- Macro: WT_LOWER_CASE_EN.
- Defined: 'g' (0x67) and 'o' (0x6F) are accepted as equivalents of 'G' and 'O', encoding to 11 and 12 and driving the same transitions.
- Undefined: 'g' and 'o' encode to 10 and cause an error in every state.

Test Plan:
- Send "12:34 GO", one byte per cycle, with CMD_READY=0 → CODE sequence 1,2,13,3,4,14,11,12 one cycle after each byte; CMD_VALID=1 with FIELD_A=0x12, FIELD_B=0x34; ASCII_READY=0 until CMD_READY.
- From that state, pulse CMD_READY for 1 cycle → CMD_VALID=0, FIELD_A=FIELD_B=0 and ASCII_READY=1 on the next cycle.
- Send "123" → third digit gives ERR pulse with CODE=3; FIELD_A=0; state S_A. Then send "5:3GO" → FIELD_A=0x05, FIELD_B=0x03.
- Send "1:2:" → ERR on the second ':'; send 'X' (0x58) in S_A → CODE=10, ERR=1.
- Send "9G" then 'Z' → ERR and no CMD_VALID. Assert RST after "12:" → all outputs at reset values; then "7GO" → FIELD_A=0x07, FIELD_B=0.
- Send "4:5go", once with WT_LOWER_CASE_EN defined and once without → with the macro, CMD_VALID with FIELD_A=0x04, FIELD_B=0x05; without it, ERR on 'g' with CODE=10.
